// File: rtl/pb_command_sequencer.sv
// Peripheral-bus command sequencer: queues parser commands, runs one engine at a
// time under a timeout, and hands a status record to the response formatter.
module pb_command_sequencer #(
  parameter int CLOCK_FREQUENCY = 27000000,
  parameter int TIMEOUT_CYCLES  = 2700,
  parameter int GAP_CYCLES      = 27,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_code,
  output logic       substate_pb_i_write4_active,
  output logic       substate_pb_read4_active,
  output logic       substate_pb_adc4_active,
  output logic       substate_pb_adc1_active,
  output logic       substate_pb_test_active,
  input  logic       substate_pb_i_write4_complete,
  input  logic       substate_pb_read4_complete,
  input  logic       substate_pb_adc4_complete,
  input  logic       substate_pb_adc1_complete,
  input  logic       substate_pb_test_complete,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [2:0] resp_cmd,
  output logic [1:0] resp_status,
  output logic       busy
);

  localparam int PTR_W = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int GAP_W = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [15:0]      TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES);

  if (CLOCK_FREQUENCY <= 0 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535 ||
      GAP_CYCLES < 0 || FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("pb_command_sequencer: illegal parameter combination");
  end

  typedef enum logic [2:0] {IDLE, DISPATCH, WAIT_COMPLETE, RESPOND, GAP} state_t;

  state_t           state_q, state_d;
  logic [2:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             cmd_ready_q;
  logic [2:0]       cur_code_q, cur_code_d;
  logic [4:0]       active_q, active_d;
  logic [15:0]      tmo_q, tmo_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             resp_valid_q, resp_valid_d;
  logic [2:0]       resp_cmd_q, resp_cmd_d;
  logic [1:0]       resp_status_q, resp_status_d;
  logic [4:0]       complete_vec;
  logic             push, pop;

  assign push = cmd_valid && cmd_ready_q;
  assign pop  = (state_q == IDLE) && (count_q != '0);
  assign complete_vec = {substate_pb_test_complete, substate_pb_adc1_complete,
                         substate_pb_adc4_complete, substate_pb_read4_complete,
                         substate_pb_i_write4_complete};

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Ready is registered from the next occupancy so a full queue refuses a push
  // even on the cycle its head is being popped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b1;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= cmd_code;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q     <= count_d;
      cmd_ready_q <= (count_d != FULL_CNT);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cur_code_q    <= '0;
      active_q      <= '0;
      tmo_q         <= '0;
      gap_q         <= '0;
      resp_valid_q  <= 1'b0;
      resp_cmd_q    <= '0;
      resp_status_q <= '0;
    end else begin
      state_q       <= state_d;
      cur_code_q    <= cur_code_d;
      active_q      <= active_d;
      tmo_q         <= tmo_d;
      gap_q         <= gap_d;
      resp_valid_q  <= resp_valid_d;
      resp_cmd_q    <= resp_cmd_d;
      resp_status_q <= resp_status_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cur_code_d    = cur_code_q;
    active_d      = active_q;
    tmo_d         = tmo_q;
    gap_d         = gap_q;
    resp_valid_d  = resp_valid_q;
    resp_cmd_d    = resp_cmd_q;
    resp_status_d = resp_status_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          cur_code_d = mem_q[rd_ptr_q];
          state_d    = DISPATCH;
        end
      end
      DISPATCH: begin
        if (cur_code_q <= 3'd4) begin
          active_d = 5'd1 << cur_code_q;
          tmo_d    = '0;
          state_d  = WAIT_COMPLETE;
        end else begin
          resp_valid_d  = 1'b1;
          resp_cmd_d    = cur_code_q;
          resp_status_d = 2'd2;
          state_d       = RESPOND;
        end
      end
      // active_q is one-hot, so masking picks out only the running engine;
      // testing complete first lets it win over the terminal count.
      WAIT_COMPLETE: begin
        if ((active_q & complete_vec) != '0) begin
          active_d      = '0;
          resp_valid_d  = 1'b1;
          resp_cmd_d    = cur_code_q;
          resp_status_d = 2'd0;
          state_d       = RESPOND;
        end else if (tmo_q == TMO_LAST) begin
          active_d      = '0;
          resp_valid_d  = 1'b1;
          resp_cmd_d    = cur_code_q;
          resp_status_d = 2'd1;
          state_d       = RESPOND;
        end else if (tmo_q != 16'hFFFF) begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      RESPOND: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          gap_d        = '0;
          state_d      = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      // GAP holds through a count of 0..GAP_CYCLES, keeping the next
      // activation GAP_CYCLES+3 cycles behind the handshake.
      GAP: begin
        if (gap_q == GAP_LAST) state_d = IDLE;
        else                   gap_d   = gap_q + GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready                   = cmd_ready_q;
  assign substate_pb_i_write4_active = active_q[0];
  assign substate_pb_read4_active    = active_q[1];
  assign substate_pb_adc4_active     = active_q[2];
  assign substate_pb_adc1_active     = active_q[3];
  assign substate_pb_test_active     = active_q[4];
  assign resp_valid                  = resp_valid_q;
  assign resp_cmd                    = resp_cmd_q;
  assign resp_status                 = resp_status_q;
  assign busy                        = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_pb_command_sequencer.sv
// Bench for pb_command_sequencer: directed vector table, hand-written FIFO-full and
// reset sequences, and random bursts checked against a rule-level reference model.
module tb_pb_command_sequencer;

  localparam int T     = 40;
  localparam int G     = 3;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_code;
  logic [4:0] activeVec;
  logic [4:0] compVec;
  logic       resp_valid;
  logic       resp_ready;
  logic [2:0] resp_cmd;
  logic [1:0] resp_status;
  logic       busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int code;
    int n;
    int rdy;
    int expStat;
    int expDur;
  } vec_t;

  vec_t vecs [9];
  int bCode [4];
  int bN    [4];
  int bRdy  [4];
  int bStat [4];
  int bDur  [4];

  always #5 clock = ~clock;

  pb_command_sequencer #(
    .CLOCK_FREQUENCY(27000000),
    .TIMEOUT_CYCLES (T),
    .GAP_CYCLES     (G),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clock                        (clock),
    .reset                        (reset),
    .cmd_valid                    (cmd_valid),
    .cmd_ready                    (cmd_ready),
    .cmd_code                     (cmd_code),
    .substate_pb_i_write4_active  (activeVec[0]),
    .substate_pb_read4_active     (activeVec[1]),
    .substate_pb_adc4_active      (activeVec[2]),
    .substate_pb_adc1_active      (activeVec[3]),
    .substate_pb_test_active      (activeVec[4]),
    .substate_pb_i_write4_complete(compVec[0]),
    .substate_pb_read4_complete   (compVec[1]),
    .substate_pb_adc4_complete    (compVec[2]),
    .substate_pb_adc1_complete    (compVec[3]),
    .substate_pb_test_complete    (compVec[4]),
    .resp_valid                   (resp_valid),
    .resp_ready                   (resp_ready),
    .resp_cmd                     (resp_cmd),
    .resp_status                  (resp_status),
    .busy                         (busy)
  );

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  task automatic checkAtLeast(input string name, input int actual, input int minimum);
    total++;
    if (actual < minimum) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want at least %0d", name, actual, minimum);
    end
  endtask

  // Reference model: the outcome of one command follows directly from its code
  // and from the active cycle on which its engine reports completion.
  function automatic int modelStatus(input int code, input int n);
    if (code > 4) return 2;
    return (n <= T) ? 0 : 1;
  endfunction

  function automatic int modelDuration(input int code, input int n);
    if (code > 4) return 0;
    return (n <= T) ? n : T;
  endfunction

  function automatic int outVec();
    return int'({activeVec, resp_valid, resp_cmd, resp_status, busy, cmd_ready});
  endfunction

  // Services one command from dispatch through the response handshake; the
  // engine raises complete on its n-th active cycle while other engines chatter.
  task automatic runCommand(input int code, input int n, input int rdy, input int waitMode,
                            input int waitVal, input int expStat, input int expDur);
    int steps;
    int dur;
    logic [4:0] onehot;
    onehot = (code <= 4) ? (5'd1 << code) : 5'd0;
    steps = 0;
    while (activeVec == 5'd0 && !resp_valid && steps < 300) begin
      @(negedge clock);
      steps++;
    end
    if (activeVec == 5'd0 && !resp_valid) begin
      total++;
      bad++;
      $display("[TB] FAIL dispatchTimeout: got no activity after %0d cycles, want dispatch of code %0d", steps, code);
      return;
    end
    if (waitMode == 1)      check("dispatchLatency", steps, waitVal);
    else if (waitMode == 2) checkAtLeast("dispatchGap", steps, waitVal);
    check("activation", activeVec, onehot);
    check("busyWhileWorking", busy, 1);
    if (expDur > 0) begin
      dur = 0;
      while (activeVec != 5'd0 && dur < T + 5) begin
        dur++;
        compVec = (5'($urandom_range(0, 31)) & ~onehot) | ((dur == n) ? onehot : 5'd0);
        @(negedge clock);
      end
      compVec = 5'd0;
      check("activeCycles", dur, expDur);
    end
    check("respValid", resp_valid, 1);
    check("respCmd", resp_cmd, code);
    check("respStatus", resp_status, expStat);
    check("activeAfterDone", activeVec, 0);
    repeat (rdy) begin
      @(negedge clock);
      check("respHold", {resp_valid, resp_cmd, resp_status}, {1'b1, 3'(code), 2'(expStat)});
    end
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    check("respDrop", resp_valid, 0);
  endtask

  task automatic doBurst(input int m);
    fork
      begin
        for (int i = 0; i < m; i++) begin
          cmd_valid = 1'b1;
          cmd_code  = 3'(bCode[i]);
          check("pushReady", cmd_ready, 1);
          @(negedge clock);
        end
        cmd_valid = 1'b0;
      end
      begin
        for (int j = 0; j < m; j++)
          runCommand(bCode[j], bN[j], bRdy[j], (j == 0) ? 1 : 2, (j == 0) ? 3 : G + 3,
                     bStat[j], bDur[j]);
      end
    join
    repeat (G + 4) @(negedge clock);
    check("idleBusy", busy, 0);
    check("idleReady", cmd_ready, 1);
  endtask

  task automatic pulseReset();
    reset = 1'b0;
    #1;
    check("resetImmediate", outVec(), 1);
    @(negedge clock);
    check("resetHeld", outVec(), 1);
    reset = 1'b1;
  endtask

  task automatic checkQuiet(input string name);
    int saw;
    saw = 0;
    repeat (T + 20) begin
      @(negedge clock);
      if (activeVec != 5'd0 || resp_valid) saw = 1;
    end
    check(name, saw, 0);
  endtask

  task automatic waitFor(input bit wantResp, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (wantResp ? resp_valid : (activeVec != 5'd0)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic applyStimulus();
    bit ok;
    // Directed vectors: {code, complete cycle, ready delay, status, active cycles}.
    vecs[0] = '{1, 11,  0, 0, 11};
    vecs[1] = '{0, 1,   2, 0, 1};
    vecs[2] = '{2, 100, 1, 1, 40};
    vecs[3] = '{3, 40,  0, 0, 40};
    vecs[4] = '{4, 39,  3, 0, 39};
    vecs[5] = '{2, 41,  0, 1, 40};
    vecs[6] = '{6, 0,   0, 2, 0};
    vecs[7] = '{5, 0,   2, 2, 0};
    vecs[8] = '{7, 0,   1, 2, 0};
    for (int v = 0; v < 9; v++) begin
      bCode[0] = vecs[v].code;
      bN[0]    = vecs[v].n;
      bRdy[0]  = vecs[v].rdy;
      bStat[0] = vecs[v].expStat;
      bDur[0]  = vecs[v].expDur;
      doBurst(1);
    end

    // Fill the queue behind a running engine, then offer one more command.
    fork
      begin
        cmd_valid = 1'b1;
        cmd_code  = 3'd1;
        @(negedge clock);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
          cmd_valid = 1'b1;
          cmd_code  = (i == 0) ? 3'd0 : 3'(i + 1);
          check("fillReady", cmd_ready, 1);
          @(negedge clock);
        end
        cmd_code = 3'd7;
        check("fullReady", cmd_ready, 0);
        @(negedge clock);
        check("fullReadyHeld", cmd_ready, 0);
        @(negedge clock);
        cmd_valid = 1'b0;
      end
      begin
        runCommand(1, 20, 0, 1, 3, 0, 20);
        runCommand(0, 2, 1, 2, G + 3, 0, 2);
        runCommand(2, 3, 0, 2, G + 3, 0, 3);
        runCommand(3, 4, 2, 2, G + 3, 0, 4);
        runCommand(4, 5, 0, 2, G + 3, 0, 5);
      end
    join
    repeat (G + 4) @(negedge clock);
    check("noExtraResp", {activeVec, resp_valid, busy}, 0);

    // Reset while an engine runs and a second command waits in the queue.
    cmd_valid = 1'b1;
    cmd_code  = 3'd0;
    @(negedge clock);
    cmd_code  = 3'd1;
    @(negedge clock);
    cmd_valid = 1'b0;
    waitFor(1'b0, ok);
    check("rstWaitActive", activeVec, 1);
    pulseReset();
    checkQuiet("quietAfterWaitReset");

    // Reset while an illegal-code response is pending.
    cmd_valid = 1'b1;
    cmd_code  = 3'd5;
    @(negedge clock);
    cmd_valid = 1'b0;
    waitFor(1'b1, ok);
    check("rstRespStatus", {resp_valid, resp_cmd, resp_status}, {1'b1, 3'd5, 2'd2});
    pulseReset();
    checkQuiet("quietAfterRespReset");

    // Random bursts into an idle queue.
    for (int b = 0; b < 12; b++) begin
      int m;
      m = $urandom_range(1, 4);
      for (int i = 0; i < m; i++) begin
        bCode[i] = $urandom_range(0, 7);
        bN[i]    = $urandom_range(1, T + 3);
        bRdy[i]  = $urandom_range(0, 3);
        bStat[i] = modelStatus(bCode[i], bN[i]);
        bDur[i]  = modelDuration(bCode[i], bN[i]);
      end
      doBurst(m);
    end
  endtask

  initial begin
    reset      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_code   = 3'd0;
    compVec    = 5'd0;
    resp_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("resetState", outVec(), 1);
    reset = 1'b1;
    @(negedge clock);
    check("resetRelease", outVec(), 1);
    applyStimulus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish by %0t, want finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
